// File: rtl/gb_xact_bridge.sv
// Ghostbus transaction bridge: one command in flight, strobe, wait, respond.
// Reads are captured READ_DELAY cycles after the read strobe.
module gb_xact_bridge #(
  parameter int ADW        = 24,
  parameter int DW         = 32,
  parameter int READ_DELAY = 3
) (
  input  logic           gb_clk,
  input  logic           gb_rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_we,
  input  logic [ADW-1:0] cmd_addr,
  input  logic [DW-1:0]  cmd_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_we,
  output logic [DW-1:0]  rsp_rdata,
  output logic [ADW-1:0] gb_addr,
  output logic [DW-1:0]  gb_wdata,
  output logic           gb_wen,
  output logic           gb_rstb,
  input  logic [DW-1:0]  gb_rdata,
  output logic [15:0]    xact_count
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP
  } state_t;

  state_t         state;
  state_t         state_n;
  logic           we_q;
  logic [3:0]     dly;
  logic [DW-1:0]  rdata_q;
  logic [15:0]    count_q;
  logic           accept;
  logic           done;

  assign accept     = cmd_valid & cmd_ready;
  assign done       = rsp_valid & rsp_ready;
  assign rsp_we     = we_q;
  assign rsp_rdata  = rdata_q;
  assign xact_count = count_q;

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    gb_wen    = 1'b0;
    gb_rstb   = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = STROBE;
      end
      STROBE: begin
        gb_wen  = we_q;
        gb_rstb = ~we_q;
        state_n = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (dly == 4'd0) state_n = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      we_q     <= 1'b0;
      gb_addr  <= '0;
      gb_wdata <= '0;
      rdata_q  <= '0;
      dly      <= 4'd0;
      count_q  <= 16'd0;
    end else begin
      if (accept) begin
        we_q     <= cmd_we;
        gb_addr  <= cmd_addr;
        gb_wdata <= cmd_wdata;
      end
      if (state == STROBE) begin
        dly <= 4'(READ_DELAY - 1);
        if (we_q) rdata_q <= '0;
      end
      // Capture happens in the WAIT cycle where the counter has reached 0
      if (state == WAIT) begin
        if (dly != 4'd0) dly     <= dly - 4'd1;
        else             rdata_q <= gb_rdata;
      end
      if (done) count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: doc/gb_xact_bridge.md
GB_XACT_BRIDGE -- requirements
Module: gb_xact_bridge

Interface
REQ-001 The block SHALL have parameter ADW, default 24, ghostbus address width.
REQ-002 The block SHALL have parameter DW, default 32, ghostbus data width.
REQ-003 The block SHALL have parameter READ_DELAY, default 3, legal range 1..15, cycles from read strobe to valid gb_rdata.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be, clock and reset first:
- gb_clk  in  1  bus clock
- gb_rst_n  in  1  async reset, active low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADW  target address
- cmd_wdata  in  DW  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_we  out  1  echo of cmd_we
- rsp_rdata  out  DW  read data; 0 for writes
- gb_addr  out  ADW  to ghostbus
- gb_wdata  out  DW  to ghostbus
- gb_wen  out  1  write strobe
- gb_rstb  out  1  read strobe
- gb_rdata  in  DW  from ghostbus
- xact_count  out  16  completed transactions

Function
REQ-006 The FSM SHALL have states IDLE, STROBE, WAIT and RESP; only one transaction SHALL be in flight.
REQ-007 cmd_ready SHALL be 1 only in IDLE.
REQ-008 On cmd_valid and cmd_ready at an edge, the block SHALL register cmd_we, cmd_addr and cmd_wdata and enter STROBE.
REQ-009 STROBE SHALL last exactly one cycle (cycle S):
- gb_addr and gb_wdata SHALL present the registered values.
- gb_wen SHALL equal the registered we.
- gb_rstb SHALL equal the inverse of the registered we.
REQ-010 gb_wen and gb_rstb SHALL be 0 in every state other than STROBE, and SHALL never be high together.
REQ-011 gb_addr and gb_wdata SHALL hold the last registered values in all states; they SHALL change only on command acceptance.
REQ-012 A write SHALL go from STROBE to RESP, with rsp_rdata forced to 0; rsp_valid SHALL rise 2 cycles after the accept edge.
REQ-013 A read SHALL go from STROBE to WAIT and load a 4-bit down-counter with READ_DELAY-1.
REQ-014 In WAIT, the counter SHALL decrement each cycle while nonzero.
REQ-015 When the counter is 0, the block SHALL capture gb_rdata into rsp_rdata at the edge ending cycle S+READ_DELAY and enter RESP.
REQ-016 Read latency SHALL therefore be: rsp_valid high in cycle S+READ_DELAY+1.
REQ-017 In RESP, rsp_valid SHALL be 1, and rsp_we and rsp_rdata SHALL be held stable until rsp_ready is sampled high.
REQ-018 On that edge, the block SHALL return to IDLE; cmd_ready SHALL then be high the next cycle.
REQ-019 cmd_valid asserted outside IDLE SHALL be ignored and not lost; the source holds it until cmd_ready.
REQ-020 xact_count SHALL increment by 1 on each rsp_valid and rsp_ready handshake and SHALL wrap 0xFFFF to 0x0000.
REQ-021 With READ_DELAY=1, WAIT SHALL last one cycle, and capture SHALL occur at the edge ending S+1.

Reset
REQ-022 Assertion of gb_rst_n low SHALL immediately force:
- state to IDLE;
- cmd_ready to 1 (once the reset is released);
- rsp_valid, rsp_we, gb_wen and gb_rstb to 0;
- gb_addr, gb_wdata, rsp_rdata, the delay counter and xact_count to 0.
REQ-023 A reset during STROBE, WAIT or RESP SHALL abandon the transaction without a response and without a count increment; no strobe SHALL be issued until a new command is accepted.

Verification
REQ-024 Write: cmd addr 0x000004, wdata 0x5, rsp_ready=1 -> gb_wen high exactly one cycle with gb_addr=0x000004 and gb_wdata=0x5; rsp_valid 2 cycles after accept with rsp_rdata=0; xact_count=1.
REQ-025 Read: READ_DELAY=3, bus stub drives gb_rdata=0xCC only in cycle S+3 -> gb_rstb one cycle; rsp_rdata=0xCC, valid in cycle S+4.
REQ-026 Backpressure: hold rsp_ready=0 for 10 cycles with cmd_valid held high -> rsp_valid, rsp_we and rsp_rdata stable; cmd_ready=0; no second strobe until one cycle after rsp_ready.
REQ-027 Reset mid-read: assert gb_rst_n low in WAIT -> outputs at reset values immediately; no rsp_valid; xact_count=0; the next read completes normally.
REQ-028 Sweep: READ_DELAY in {1,3,15}, a 46-entry write-then-read-back of the top address map -> all readbacks match, and gb_wen/gb_rstb are never high together.
REQ-029 Wrap: preload xact_count to 0xFFFF, one transaction -> xact_count=0x0000.
